// File: rtl/serial_sample_rx_if.sv
// serial_sample_rx_if: serial pin inputs and assembled-word outputs of the sample receiver.
interface serial_sample_rx_if #(parameter int W = 16);
  logic         sclk_in;
  logic         fs_in;
  logic         sdata_in;
  logic [W-1:0] sample_out;
  logic         sample_valid;
  logic         frame_err;
  logic         busy;
  modport master (output sclk_in, fs_in, sdata_in, input sample_out, sample_valid, frame_err, busy);
  modport slave  (input sclk_in, fs_in, sdata_in, output sample_out, sample_valid, frame_err, busy);
endinterface

// File: rtl/serial_sample_rx.sv
// serial_sample_rx: oversamples a slow serial clock/fs/data link and assembles MSB-first W-bit words.
module serial_sample_rx #(
  parameter int W       = 16,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 10
) (
  input logic              clk,
  input logic              rst_n,
  serial_sample_rx_if.slave bus
);
  localparam int CW = $clog2(W);
  localparam int SW = W - 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [2:0]    sclk_q;
  logic [1:0]    fs_q, sd_q;
  logic [0:0]    state_q, state_d;
  logic [SW-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [W-1:0]  sample_q, sample_d;
  logic          valid_q, valid_d, ferr_q, ferr_d;
  logic          sclk_rise, fs_s, sd_s, last_bit;
  logic [SW-1:0] first_bits;
  // shreg keeps only the W-1 older bits; the newest bit joins them when the word completes
  assign sclk_rise  = sclk_q[1] & ~sclk_q[2];
  assign fs_s       = fs_q[1];
  assign sd_s       = sd_q[1];
  assign last_bit   = cnt_q == CW'(W - 1);
  assign first_bits = SW'(sd_s);
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    if (state_q == IDLE) begin
      if (sclk_rise && fs_s) begin
        shreg_d = first_bits;
        cnt_d   = CW'(1);
        tcnt_d  = '0;
        state_d = SHIFT;
      end
    end else if (sclk_rise) begin
      tcnt_d = '0;
      if (last_bit) begin
        sample_d = {shreg_q, sd_s};
        valid_d  = 1'b1;
        shreg_d  = fs_s ? first_bits : '0;
        cnt_d    = fs_s ? CW'(1) : '0;
        state_d  = fs_s ? SHIFT : IDLE;
      end else begin
        ferr_d  = fs_s;
        shreg_d = fs_s ? first_bits : SW'({shreg_q, sd_s});
        cnt_d   = fs_s ? CW'(1) : cnt_q + 1'b1;
      end
    end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
      ferr_d  = 1'b1;
      shreg_d = '0;
      cnt_d   = '0;
      tcnt_d  = '0;
      state_d = IDLE;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q   <= '0;
      fs_q     <= '0;
      sd_q     <= '0;
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sclk_q   <= {sclk_q[1:0], bus.sclk_in};
      fs_q     <= {fs_q[0], bus.fs_in};
      sd_q     <= {sd_q[0], bus.sdata_in};
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end
  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.frame_err    = ferr_q;
  assign bus.busy         = state_q == SHIFT;
endmodule

// File: tb/tb_serial_sample_rx.sv
// tb_serial_sample_rx: table of frames plus hand-written error/timeout/reset/noise sequences, scoreboard-checked.
module tb_serial_sample_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   valid_cyc = -1;
  int   err_cyc = -1;
  typedef struct { logic err; logic [15:0] val; } ev_t;
  typedef struct { logic [15:0] word; int gap; logic [15:0] exp; } vec_t;
  ev_t  exp_q[$];
  ev_t  mon_e;
  vec_t vecs[6];
  serial_sample_rx_if #(.W(16)) bus ();
  serial_sample_rx #(.W(16), .TIMEOUT(64), .TW(7)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && (bus.sample_valid || bus.frame_err)) begin
      chk("valid_err_exclusive", {31'b0, bus.sample_valid & bus.frame_err}, 32'd0);
      chk("event_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("event_kind_is_err", {31'b0, bus.frame_err}, {31'b0, mon_e.err});
        if (!mon_e.err) chk("sample_out", {16'b0, bus.sample_out}, {16'b0, mon_e.val});
      end
      if (bus.sample_valid) valid_cyc = cyc;
      if (bus.frame_err) err_cyc = cyc;
    end
  end
  task automatic send_bit(input logic f, input logic b, output int t);
    bus.fs_in = f;
    bus.sdata_in = b;
    bus.sclk_in = 1'b0;
    repeat (8) @(negedge clk);
    bus.sclk_in = 1'b1;
    t = cyc;
    repeat (8) @(negedge clk);
  endtask
  task automatic idle(input int n);
    bus.sclk_in = 1'b0;
    bus.fs_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_word(input logic [15:0] w, output int t_first);
    int t;
    exp_q.push_back('{err: 1'b0, val: w});
    t_first = 0;
    for (int i = 15; i >= 0; i--) begin
      send_bit(i == 15, w[i], t);
      if (i == 15) t_first = t;
      if (i > 0) chk("busy_mid_frame", {31'b0, bus.busy}, 32'd1);
    end
    chk("busy_after_frame", {31'b0, bus.busy}, 32'd0);
    chk("valid_latency", valid_cyc, t + 3);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t, t0, tf, prev_valid;
    vecs[0] = '{16'hA5C3, 2, 16'hA5C3};
    vecs[1] = '{16'h0001, 0, 16'h0001};
    vecs[2] = '{16'hFFFF, 2, 16'hFFFF};
    vecs[3] = '{16'h0000, 1, 16'h0000};
    vecs[4] = '{16'h5A5A, 0, 16'h5A5A};
    vecs[5] = '{16'h7FFE, 3, 16'h7FFE};
    bus.sclk_in = 1'b0;
    bus.fs_in = 1'b0;
    bus.sdata_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_sample_out", {16'b0, bus.sample_out}, 32'd0);
    chk("reset_valid", {31'b0, bus.sample_valid}, 32'd0);
    chk("reset_err", {31'b0, bus.frame_err}, 32'd0);
    chk("reset_busy", {31'b0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    idle(4);
    prev_valid = 0;
    foreach (vecs[i]) begin
      send_word(vecs[i].word, tf);
      chk("table_sample_out", {16'b0, bus.sample_out}, {16'b0, vecs[i].exp});
      if (i > 0 && vecs[i-1].gap == 0) chk("b2b_spacing", valid_cyc - prev_valid, 256);
      prev_valid = valid_cyc;
      idle(16 * vecs[i].gap);
    end
    // fs re-asserted on the 6th edge: error, then that edge carries the MSB of 0x1234
    exp_q.push_back('{err: 1'b1, val: 16'h0});
    send_bit(1'b1, 1'b1, t);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'(i), t);
    send_word(16'h1234, tf);
    chk("reframe_err_cycle", err_cyc, tf + 3);
    chk("reframe_sample", {16'b0, bus.sample_out}, 32'h1234);
    idle(32);
    // 8 bits then silence: abort exactly 64 cycles after the 8th edge's action cycle
    exp_q.push_back('{err: 1'b1, val: 16'h0});
    for (int i = 7; i >= 0; i--) send_bit(i == 7, 1'(8'hA7 >> i), t0);
    bus.sclk_in = 1'b0;
    repeat (t0 + 66 - cyc) @(negedge clk);
    chk("timeout_busy_before", {31'b0, bus.busy}, 32'd1);
    chk("timeout_err_before", {31'b0, bus.frame_err}, 32'd0);
    @(negedge clk);
    chk("timeout_err", {31'b0, bus.frame_err}, 32'd1);
    chk("timeout_busy_drop", {31'b0, bus.busy}, 32'd0);
    chk("timeout_sample_held", {16'b0, bus.sample_out}, 32'h1234);
    idle(8);
    send_word(16'h00FF, tf);
    chk("after_timeout_sample", {16'b0, bus.sample_out}, 32'h00FF);
    idle(16);
    // reset in the middle of a frame
    for (int i = 15; i >= 6; i--) send_bit(i == 15, 1'(16'hBEEF >> i), t);
    bus.sclk_in = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_sample_out", {16'b0, bus.sample_out}, 32'd0);
    chk("midreset_valid", {31'b0, bus.sample_valid}, 32'd0);
    chk("midreset_err", {31'b0, bus.frame_err}, 32'd0);
    chk("midreset_busy", {31'b0, bus.busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(40);
    chk("post_reset_sample_out", {16'b0, bus.sample_out}, 32'd0);
    send_word(16'h8001, tf);
    chk("post_reset_sample", {16'b0, bus.sample_out}, 32'h8001);
    idle(16);
    // edges with fs low while idle must be ignored
    for (int i = 0; i < 40; i++) begin
      send_bit(1'b0, 1'($urandom), t);
      chk("noise_busy", {31'b0, bus.busy}, 32'd0);
    end
    idle(80);
    chk("noise_sample_held", {16'b0, bus.sample_out}, 32'h8001);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
